// File: rtl/clock_forward.sv
`default_nettype none
// ============================================================================
// Module      : clock_forward
// Description : Forwards a divided copy of clk_int to an output pin, either
//               single-ended or as a complementary pair. It supports burst
//               or free-running operation, glitch-free start/stop and
//               phase-aligned divider updates.
// Revision    : 1.0  initial release
// ============================================================================
module clock_forward #(
    parameter int DIFF        = 0,
    parameter int DIV_WIDTH   = 8,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk_int,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_WIDTH-1:0]   div_val,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   pin_clk_p,
    output logic                   pin_clk_n,
    output logic                   running,
    output logic                   done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DIV_WIDTH-1:0]   DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] PCNT_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] PCNT_MAX = {BURST_WIDTH{1'b1}};

    logic [0:0]             state,    state_nx;
    logic                   clk_o,    clk_o_nx;
    logic [DIV_WIDTH-1:0]   cnt,      cnt_nx;
    logic [DIV_WIDTH-1:0]   div_lat,  div_lat_nx;
    logic [BURST_WIDTH-1:0] blen_lat, blen_lat_nx;
    logic [BURST_WIDTH-1:0] pcnt,     pcnt_nx;
    logic                   done_nx;
    logic                   burst_hit;

    // A burst is complete once the number of issued rising edges equals the
    // latched length; a zero length never matches, so free-running keeps going.
    assign burst_hit = (blen_lat != '0) && (pcnt == blen_lat);

    // Next-state logic. Phase boundaries happen only when cnt reaches zero,
    // and the stop decision is taken only at the end of a low phase.
    always_comb begin
        state_nx    = state;
        clk_o_nx    = clk_o;
        cnt_nx      = cnt;
        div_lat_nx  = div_lat;
        blen_lat_nx = blen_lat;
        pcnt_nx     = pcnt;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx    = RUN;
                    clk_o_nx    = 1'b0;
                    cnt_nx      = div_val;
                    div_lat_nx  = div_val;
                    blen_lat_nx = burst_len;
                    pcnt_nx     = '0;
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - DIV_ONE;
                end else if (clk_o) begin
                    // End of a high phase: always falls, even if en dropped.
                    clk_o_nx = 1'b0;
                    cnt_nx   = div_lat;
                end else if (!en || burst_hit) begin
                    // End of a low phase: stop without issuing another edge.
                    state_nx = IDLE;
                    clk_o_nx = 1'b0;
                    done_nx  = burst_hit;
                end else begin
                    // Rising toggle: the only point where div_val is picked up.
                    clk_o_nx   = 1'b1;
                    div_lat_nx = div_val;
                    cnt_nx     = div_val;
                    if (pcnt != PCNT_MAX) begin
                        pcnt_nx = pcnt + PCNT_ONE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                clk_o_nx = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_int) begin
        if (rst) begin
            state    <= IDLE;
            clk_o    <= 1'b0;
            cnt      <= '0;
            div_lat  <= '0;
            blen_lat <= '0;
            pcnt     <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            clk_o    <= clk_o_nx;
            cnt      <= cnt_nx;
            div_lat  <= div_lat_nx;
            blen_lat <= blen_lat_nx;
            pcnt     <= pcnt_nx;
            done     <= done_nx;
        end
    end

    assign pin_clk_p = clk_o;
    assign running   = (state == RUN);

    generate
        if (DIFF != 0) begin : g_diff
            logic clk_n;
            // Separate flop for the complement so both pins switch together.
            always_ff @(posedge clk_int) begin
                if (rst) begin
                    clk_n <= 1'b1;
                end else begin
                    clk_n <= ~clk_o_nx;
                end
            end
            assign pin_clk_n = clk_n;
        end else begin : g_single
            assign pin_clk_n = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire
